// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM pipeline stage and its data cache.
// Holds the cache geometry constants, the miss-handling FSM state encoding,
// and helpers for selecting and merging words and byte lanes inside a line.
// There are no ports because this file is a package.
package pipeline_pkg;

  localparam int WORD_BITS   = 32;
  localparam int LINE_BITS   = 128;
  localparam int OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVICT  = 2'd1,
    ST_FILL   = 2'd2,
    ST_REPLAY = 2'd3
  } dcacheState_e;

  // Word 0 sits in line bits [31:0].
  function automatic logic [WORD_BITS-1:0] getWord(input logic [LINE_BITS-1:0] line,
                                                   input logic [1:0] sel);
    return line[{sel, 5'b00000} +: WORD_BITS];
  endfunction

  function automatic logic [LINE_BITS-1:0] setWord(input logic [LINE_BITS-1:0] line,
                                                   input logic [1:0] sel,
                                                   input logic [WORD_BITS-1:0] word);
    logic [LINE_BITS-1:0] v;
    v = line;
    v[{sel, 5'b00000} +: WORD_BITS] = word;
    return v;
  endfunction

  // Little-endian byte lanes: lane 0 is word bits [7:0].
  function automatic logic [7:0] getByte(input logic [WORD_BITS-1:0] word,
                                         input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [WORD_BITS-1:0] setByte(input logic [WORD_BITS-1:0] word,
                                                   input logic [1:0] lane,
                                                   input logic [7:0] data);
    logic [WORD_BITS-1:0] v;
    v = word;
    v[{lane, 3'b000} +: 8] = data;
    return v;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Storage for the direct-mapped data cache.
// This module holds the tag, valid and dirty state plus the line data for
// each cache line. Reads are combinational at i_index. Writes happen at the
// clock edge and use one port for both line fills and store merges. Reset
// clears valid and dirty asynchronously. Data contents are not reset.
// Ports:
//   clk, reset          clock and async active-high reset
//   i_index             line selected for the read and the write
//   i_we                write the selected line (sets valid)
//   i_wTag/i_wLine      new tag and line data
//   i_wDirty            dirty bit to store with the write
//   o_valid/o_dirty     state of the selected line
//   o_tag/o_line        tag and data of the selected line
module dcache_array
  import pipeline_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IDX_BITS  = 2,
  parameter int TAG_BITS  = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_BITS-1:0]  i_index,
  input  logic                 i_we,
  input  logic [TAG_BITS-1:0]  i_wTag,
  input  logic [LINE_BITS-1:0] i_wLine,
  input  logic                 i_wDirty,
  output logic                 o_valid,
  output logic                 o_dirty,
  output logic [TAG_BITS-1:0]  o_tag,
  output logic [LINE_BITS-1:0] o_line
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
  logic [LINE_BITS-1:0] r_data [NUM_LINES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        r_tag[i] <= '0;
      end
    end else if (i_we) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= i_wDirty;
      r_tag[i_index]   <= i_wTag;
    end
  end

  // Line data needs no reset because it is never used while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_data[i_index] <= i_wLine;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_line  = r_data[i_index];

endmodule

// File: rtl/mem_stage_dcache.sv
// MEM pipeline stage with a direct-mapped, write-back, write-allocate data cache.
// Hits complete in the same cycle. A miss raises stall_mem and runs an optional
// eviction and then a line fill. After the fill, one replay cycle passes and the
// held access then hits.
// Ports:
//   clk, reset                      clock and async active-high reset
//   ex_*                            instruction in the EX/MEM slot
//   wb_data_out/rd_out/is_write_out/mov_rm_out   outputs to the MEM/WB register
//   stall_mem                       miss in progress (upstream freezes)
//   mem_req/mem_we/mem_addr/mem_wdata            line request to main memory
//   mem_rdata/mem_ready             fill data and one-cycle completion pulse
module mem_stage_dcache
  import pipeline_pkg::*;
#(
  parameter int NUM_LINES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic                 ex_is_store,
  input  logic                 ex_is_byte,
  input  logic [31:0]          ex_addr,
  input  logic [31:0]          ex_store_data,
  input  logic [31:0]          ex_alu_result,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_is_write,
  input  logic                 ex_mov_rm,
  output logic [31:0]          wb_data_out,
  output logic [4:0]           rd_out,
  output logic                 is_write_out,
  output logic                 mov_rm_out,
  output logic                 stall_mem,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ready
);

  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = WORD_BITS - OFFSET_BITS - IDX_BITS;

  dcacheState_e r_state;
  dcacheState_e w_nextState;

  logic [IDX_BITS-1:0]  w_index;
  logic [TAG_BITS-1:0]  w_tag;
  logic [1:0]           w_wordSel;
  logic [1:0]           w_lane;
  logic                 w_isStore;
  logic                 w_isLoad;
  logic                 w_access;
  logic                 w_hit;
  logic                 w_lineValid;
  logic                 w_lineDirty;
  logic [TAG_BITS-1:0]  w_lineTag;
  logic [LINE_BITS-1:0] w_lineData;
  logic [31:0]          w_curWord;
  logic [31:0]          w_newWord;
  logic [31:0]          w_loadData;
  logic                 w_fillWe;
  logic                 w_storeWe;
  logic                 w_arrWe;
  logic [LINE_BITS-1:0] w_arrLine;

  assign w_index   = ex_addr[OFFSET_BITS +: IDX_BITS];
  assign w_tag     = ex_addr[31 -: TAG_BITS];
  assign w_wordSel = ex_addr[3:2];
  assign w_lane    = ex_addr[1:0];

  // When load and store are both set, the instruction is treated as a store.
  assign w_isStore = ex_valid && ex_is_store;
  assign w_isLoad  = ex_valid && ex_is_load && !ex_is_store;
  assign w_access  = w_isStore || w_isLoad;
  assign w_hit     = w_lineValid && (w_lineTag == w_tag);

  dcache_array #(
    .NUM_LINES(NUM_LINES),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_index (w_index),
    .i_we    (w_arrWe),
    .i_wTag  (w_tag),
    .i_wLine (w_arrLine),
    .i_wDirty(!w_fillWe),
    .o_valid (w_lineValid),
    .o_dirty (w_lineDirty),
    .o_tag   (w_lineTag),
    .o_line  (w_lineData)
  );

  // Store data is merged into the current line contents. A fill overwrites the whole line.
  assign w_curWord  = getWord(w_lineData, w_wordSel);
  assign w_newWord  = ex_is_byte ? setByte(w_curWord, w_lane, ex_store_data[7:0]) : ex_store_data;
  assign w_loadData = ex_is_byte ? {24'b0, getByte(w_curWord, w_lane)} : w_curWord;

  assign w_fillWe  = (r_state == ST_FILL) && mem_ready;
  assign w_storeWe = (r_state == ST_IDLE) && w_isStore && w_hit;
  assign w_arrWe   = w_fillWe || w_storeWe;
  assign w_arrLine = w_fillWe ? mem_rdata : setWord(w_lineData, w_wordSel, w_newWord);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_access && !w_hit) w_nextState = w_lineDirty ? ST_EVICT : ST_FILL;
      ST_EVICT:  if (mem_ready) w_nextState = ST_FILL;
      ST_FILL:   if (mem_ready) w_nextState = ST_REPLAY;
      ST_REPLAY: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // The victim address is rebuilt from the stored tag. Upstream holds the inputs stable
  // during a stall, so this address and the victim data stay fixed until mem_ready.
  always_comb begin
    stall_mem = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_IDLE: stall_mem = w_access && !w_hit;
      ST_EVICT: begin
        stall_mem = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {w_lineTag, w_index, {OFFSET_BITS{1'b0}}};
        mem_wdata = w_lineData;
      end
      ST_FILL: begin
        stall_mem = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {w_tag, w_index, {OFFSET_BITS{1'b0}}};
      end
      ST_REPLAY: stall_mem = 1'b1;
      default: stall_mem = 1'b0;
    endcase
    if (reset) stall_mem = 1'b0;
  end

  always_comb begin
    wb_data_out  = '0;
    rd_out       = '0;
    is_write_out = 1'b0;
    mov_rm_out   = 1'b0;
    if (!reset && ex_valid && !stall_mem) begin
      rd_out       = ex_rd;
      is_write_out = ex_is_write && !ex_is_store;
      mov_rm_out   = ex_mov_rm;
      if (w_isLoad) begin
        wb_data_out = w_loadData;
      end else if (!ex_is_store) begin
        wb_data_out = ex_alu_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_dcache.sv
module tb_mem_stage_dcache;

  logic         clk = 1'b0;
  logic         reset;
  logic         ex_valid, ex_is_load, ex_is_store, ex_is_byte;
  logic [31:0]  ex_addr, ex_store_data, ex_alu_result;
  logic [4:0]   ex_rd;
  logic         ex_is_write, ex_mov_rm;
  logic [31:0]  wb_data_out;
  logic [4:0]   rd_out;
  logic         is_write_out, mov_rm_out, stall_mem;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  mem_stage_dcache #(.NUM_LINES(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_is_byte(ex_is_byte), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .ex_alu_result(ex_alu_result), .ex_rd(ex_rd), .ex_is_write(ex_is_write),
    .ex_mov_rm(ex_mov_rm), .wb_data_out(wb_data_out), .rd_out(rd_out),
    .is_write_out(is_write_out), .mov_rm_out(mov_rm_out), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Main memory responder state
  int          memDelay = 0;
  int          waitCnt = -1;
  bit [31:0]   ramWord [bit [31:0]];
  int          nEvict = 0;
  int          nFill = 0;
  logic [31:0] lastEvictAddr = '0;
  logic [31:0] lastFillAddr = '0;
  logic [127:0] lastEvictData = '0;

  // Reference model: architectural memory view, model of RAM contents, line residency
  bit [31:0] archWord [bit [31:0]];
  bit [31:0] modelRam [bit [31:0]];
  bit        mValid [4];
  bit        mDirty [4];
  bit [31:0] mLine [4];

  // Values captured by issue
  int          gotStalls;
  logic [31:0] gotWb;
  logic [4:0]  gotRd;
  logic        gotWr, gotMov, gotReq;
  int          evBefore, fillBefore;

  // Model outputs
  int        expStalls;
  bit        expEvict, expFill;
  bit [31:0] expEvictAddr, expLoad;
  bit [127:0] expEvictData;

  function automatic bit [31:0] initWord(input bit [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic bit [31:0] rdRam(input bit [31:0] a);
    return ramWord.exists(a) ? ramWord[a] : initWord(a);
  endfunction

  function automatic bit [31:0] rdArch(input bit [31:0] a);
    return archWord.exists(a) ? archWord[a] : initWord(a);
  endfunction

  function automatic bit [31:0] rdModelRam(input bit [31:0] a);
    return modelRam.exists(a) ? modelRam[a] : initWord(a);
  endfunction

  // kind: 0 = ALU, 1 = load, 2 = store, 3 = load+store (store)
  function automatic void modelAccess(input int kind, input bit isByte, input bit [31:0] addr,
                                      input bit [31:0] data, input int delay);
    bit [31:0] lineA, wordA, w;
    int idx, sh, nTrans;
    expStalls = 0; expEvict = 0; expFill = 0; expEvictAddr = 0; expEvictData = 0; expLoad = 0;
    if (kind == 0) return;
    lineA = addr & 32'hFFFF_FFF0;
    wordA = addr & 32'hFFFF_FFFC;
    idx = int'(addr[5:4]);
    if (!(mValid[idx] && mLine[idx] == lineA)) begin
      nTrans = 1;
      if (mValid[idx] && mDirty[idx]) begin
        expEvict = 1;
        nTrans = 2;
        expEvictAddr = mLine[idx];
        for (int k = 0; k < 4; k++) begin
          expEvictData[32*k +: 32] = rdArch(mLine[idx] + 32'(4*k));
          modelRam[mLine[idx] + 32'(4*k)] = expEvictData[32*k +: 32];
        end
      end
      expFill = 1;
      expStalls = 2 + nTrans * (delay + 1);
      mValid[idx] = 1;
      mLine[idx] = lineA;
      mDirty[idx] = 0;
    end
    w = rdArch(wordA);
    sh = 8 * int'(addr[1:0]);
    if (kind >= 2) begin
      if (isByte) w = (w & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
      else w = data;
      archWord[wordA] = w;
      mDirty[idx] = 1;
    end else begin
      expLoad = isByte ? ((w >> sh) & 32'hFF) : w;
    end
  endfunction

  // Dirty lines lost to a reset fall back to whatever RAM holds.
  function automatic void modelReset();
    for (int i = 0; i < 4; i++) begin
      if (mValid[i] && mDirty[i]) begin
        for (int k = 0; k < 4; k++) archWord[mLine[i] + 32'(4*k)] = rdModelRam(mLine[i] + 32'(4*k));
      end
      mValid[i] = 0;
      mDirty[i] = 0;
    end
  endfunction

  // Main memory: completes a request memDelay cycles after first seeing it.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (reset) begin
      waitCnt = -1;
    end else if (mem_req === 1'b1) begin
      if (waitCnt < 0) waitCnt = memDelay;
      if (waitCnt == 0) begin
        if (mem_we) begin
          for (int k = 0; k < 4; k++) ramWord[mem_addr + 32'(4*k)] = mem_wdata[32*k +: 32];
          nEvict++;
          lastEvictAddr = mem_addr;
          lastEvictData = mem_wdata;
        end else begin
          for (int k = 0; k < 4; k++) mem_rdata[32*k +: 32] = rdRam(mem_addr + 32'(4*k));
          nFill++;
          lastFillAddr = mem_addr;
        end
        mem_ready = 1'b1;
        waitCnt = -1;
      end else begin
        waitCnt--;
      end
    end
  end

  task automatic issue(input int kind, input bit isByte, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] alu, input logic [4:0] rd,
                       input bit wr, input bit mov);
    @(negedge clk);
    ex_valid = 1'b1;
    ex_is_load = (kind == 1 || kind == 3);
    ex_is_store = (kind >= 2);
    ex_is_byte = isByte;
    ex_addr = addr;
    ex_store_data = data;
    ex_alu_result = alu;
    ex_rd = rd;
    ex_is_write = wr;
    ex_mov_rm = mov;
    evBefore = nEvict;
    fillBefore = nFill;
    #1;
    gotReq = mem_req;
    gotStalls = 0;
    while (stall_mem === 1'b1 && gotStalls < 200) begin
      gotStalls++;
      @(posedge clk);
      #1;
    end
    gotWb = wb_data_out;
    gotRd = rd_out;
    gotWr = is_write_out;
    gotMov = mov_rm_out;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    ex_is_load = 1'b0;
    ex_is_store = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_is_byte = 1'b0;
    ex_addr = 32'h100; ex_store_data = 32'h0; ex_alu_result = 32'h55;
    ex_rd = 5'd5; ex_is_write = 1'b1; ex_mov_rm = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_mem); end
    total++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL reset_req got=%b%b want=00", mem_req, mem_we); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
    total++; if ({wb_data_out, rd_out, is_write_out, mov_rm_out} !== 39'h0) begin bad++;
      $display("FAIL reset_outputs got=%h/%0d/%b/%b want=0", wb_data_out, rd_out, is_write_out, mov_rm_out); end
    @(posedge clk);
    #2;
    reset = 1'b0;
    ex_valid = 1'b0;
    ex_is_load = 1'b0;
    #1;
    total++; if (stall_mem !== 1'b0 || rd_out !== 5'd0) begin bad++; $display("FAIL idle_after_reset stall=%b rd=%0d want=0", stall_mem, rd_out); end
    modelReset();
  endtask

  task automatic test_cold_load();
    ramWord[32'h100] = 32'hDEADBEEF;
    modelRam[32'h100] = 32'hDEADBEEF;
    archWord[32'h100] = 32'hDEADBEEF;
    memDelay = 0;
    modelAccess(1, 0, 32'h100, 0, 0);
    issue(1, 0, 32'h100, 32'h0, 32'h0, 5'd3, 1, 0);
    total++; if (gotStalls != 3) begin bad++; $display("FAIL cold_stalls got=%0d want=3", gotStalls); end
    total++; if (nFill != fillBefore + 1 || lastFillAddr !== 32'h100) begin bad++;
      $display("FAIL cold_fill_addr got=%h fills=%0d want=00000100", lastFillAddr, nFill - fillBefore); end
    total++; if (gotWb !== 32'hDEADBEEF) begin bad++; $display("FAIL cold_data got=%h want=deadbeef", gotWb); end
    total++; if (gotWr !== 1'b1 || gotRd !== 5'd3) begin bad++; $display("FAIL cold_rd got=%b/%0d want=1/3", gotWr, gotRd); end
  endtask

  task automatic test_byte_store_load();
    modelAccess(2, 1, 32'h102, 32'h123456AA, 0);
    issue(2, 1, 32'h102, 32'h123456AA, 32'h0, 5'd4, 1, 0);
    total++; if (gotStalls != 0 || nFill != fillBefore) begin bad++; $display("FAIL stb_hit stalls=%0d want=0", gotStalls); end
    total++; if (gotWr !== 1'b0) begin bad++; $display("FAIL stb_no_write got=%b want=0", gotWr); end
    modelAccess(1, 1, 32'h102, 0, 0);
    issue(1, 1, 32'h102, 32'h0, 32'h0, 5'd5, 1, 0);
    total++; if (gotWb !== 32'h000000AA) begin bad++; $display("FAIL ldb_data got=%h want=000000aa", gotWb); end
    modelAccess(1, 0, 32'h100, 0, 0);
    issue(1, 0, 32'h100, 32'h0, 32'h0, 5'd6, 1, 0);
    total++; if (gotWb !== 32'hDEAABEEF || gotStalls != 0) begin bad++;
      $display("FAIL ldw_merged got=%h stalls=%0d want=deaabeef/0", gotWb, gotStalls); end
  endtask

  task automatic test_dirty_conflict();
    modelAccess(1, 0, 32'h140, 0, 0);
    issue(1, 0, 32'h140, 32'h0, 32'h0, 5'd8, 1, 0);
    total++; if (gotStalls != 4) begin bad++; $display("FAIL evict_stalls got=%0d want=4", gotStalls); end
    total++; if (nEvict != evBefore + 1 || lastEvictAddr !== 32'h100) begin bad++;
      $display("FAIL evict_addr got=%h n=%0d want=00000100", lastEvictAddr, nEvict - evBefore); end
    total++; if (lastEvictData !== expEvictData || lastEvictData[31:0] !== 32'hDEAABEEF) begin bad++;
      $display("FAIL evict_data got=%h want=%h", lastEvictData, expEvictData); end
    total++; if (lastFillAddr !== 32'h140 || gotWb !== expLoad) begin bad++;
      $display("FAIL evict_fill got=%h data=%h want=00000140/%h", lastFillAddr, gotWb, expLoad); end
    modelAccess(1, 0, 32'h180, 0, 0);
    issue(1, 0, 32'h180, 32'h0, 32'h0, 5'd9, 1, 0);
    total++; if (nEvict != evBefore || gotStalls != 3) begin bad++;
      $display("FAIL clean_victim evicts=%0d stalls=%0d want=0/3", nEvict - evBefore, gotStalls); end
  endtask

  task automatic test_alu();
    modelAccess(0, 0, 32'h0, 0, 0);
    issue(0, 0, 32'h140, 32'h0, 32'h1234, 5'd7, 1, 1);
    total++; if (gotWb !== 32'h1234 || gotRd !== 5'd7) begin bad++; $display("FAIL alu_pass got=%h/%0d want=1234/7", gotWb, gotRd); end
    total++; if (gotStalls != 0 || gotReq !== 1'b0 || nFill != fillBefore) begin bad++;
      $display("FAIL alu_no_mem stalls=%0d req=%b want=0/0", gotStalls, gotReq); end
    total++; if (gotMov !== 1'b1 || gotWr !== 1'b1) begin bad++; $display("FAIL alu_flags got=%b%b want=11", gotMov, gotWr); end
  endtask

  task automatic test_reset_in_fill();
    modelAccess(1, 0, 32'h110, 0, 0);
    issue(1, 0, 32'h110, 32'h0, 32'h0, 5'd1, 1, 0);
    @(negedge clk);
    memDelay = 10;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_is_byte = 1'b0; ex_addr = 32'h200;
    repeat (2) @(posedge clk);
    #1;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200) begin bad++;
      $display("FAIL fill_pending req=%b we=%b addr=%h want=1/0/00000200", mem_req, mem_we, mem_addr); end
    reset = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0 || stall_mem !== 1'b0 || mem_addr !== 32'h0) begin bad++;
      $display("FAIL reset_abort req=%b stall=%b addr=%h want=0/0/0", mem_req, stall_mem, mem_addr); end
    ex_valid = 1'b0;
    ex_is_load = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    memDelay = 0;
    modelAccess(1, 0, 32'h110, 0, 0);
    issue(1, 0, 32'h110, 32'h0, 32'h0, 5'd2, 1, 0);
    total++; if (gotStalls != 3 || gotStalls != expStalls) begin bad++; $display("FAIL reset_invalidates got=%0d want=3", gotStalls); end
    modelAccess(1, 0, 32'h200, 0, 0);
    issue(1, 0, 32'h200, 32'h0, 32'h0, 5'd2, 1, 0);
    total++; if (gotStalls != 3 || gotWb !== expLoad) begin bad++;
      $display("FAIL refetch got=%0d/%h want=3/%h", gotStalls, gotWb, expLoad); end
  endtask

  task automatic test_slow_memory();
    int cyc, evCyc, fiCyc;
    bit haveLat;
    logic latWe;
    logic [31:0] latAddr, sd;
    memDelay = 0;
    sd = $urandom;
    modelAccess(2, 0, 32'h120, sd, 0);
    issue(2, 0, 32'h120, sd, 32'h0, 5'd3, 0, 0);
    memDelay = 5;
    modelAccess(1, 0, 32'h1A0, 0, 5);
    @(negedge clk);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_is_byte = 1'b0;
    ex_addr = 32'h1A0; ex_rd = 5'd9; ex_is_write = 1'b1; ex_mov_rm = 1'b1;
    evBefore = nEvict;
    #1;
    cyc = 0; evCyc = 0; fiCyc = 0; haveLat = 0; latWe = 1'b0; latAddr = '0;
    while (stall_mem === 1'b1 && cyc < 200) begin
      cyc++;
      total++; if ({wb_data_out, rd_out, is_write_out, mov_rm_out} !== 39'h0) begin bad++;
        $display("FAIL slow_bubble cyc=%0d got=%h/%0d/%b/%b want=0", cyc, wb_data_out, rd_out, is_write_out, mov_rm_out); end
      if (mem_req === 1'b1) begin
        if (mem_we) evCyc++; else fiCyc++;
        if (haveLat && latWe == mem_we) begin
          total++; if (mem_addr !== latAddr) begin bad++; $display("FAIL slow_addr_stable got=%h want=%h", mem_addr, latAddr); end
        end else begin
          haveLat = 1; latWe = mem_we; latAddr = mem_addr;
        end
      end
      @(posedge clk);
      #1;
    end
    total++; if (cyc != 14 || cyc != expStalls) begin bad++; $display("FAIL slow_stalls got=%0d want=14", cyc); end
    total++; if (evCyc != 6 || fiCyc != 6) begin bad++; $display("FAIL slow_req_hold got=%0d/%0d want=6/6", evCyc, fiCyc); end
    total++; if (lastEvictAddr !== 32'h120 || lastEvictData[31:0] !== sd || nEvict != evBefore + 1) begin bad++;
      $display("FAIL slow_evict got=%h/%h want=00000120/%h", lastEvictAddr, lastEvictData[31:0], sd); end
    total++; if (wb_data_out !== expLoad || lastFillAddr !== 32'h1A0) begin bad++;
      $display("FAIL slow_data got=%h want=%h", wb_data_out, expLoad); end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    ex_is_load = 1'b0;
    memDelay = 0;
  endtask

  task automatic test_random();
    int kind, r, d;
    bit isByte, wr, mov;
    logic [31:0] addr, data, alu;
    logic [4:0] rd;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      kind = (r < 2) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      isByte = 1'($urandom_range(0, 1));
      addr = 32'h400 + 32'($urandom_range(0, 255));
      data = $urandom;
      alu = $urandom;
      rd = 5'($urandom_range(0, 31));
      wr = 1'($urandom_range(0, 1));
      mov = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 3);
      memDelay = d;
      modelAccess(kind, isByte, addr, data, d);
      issue(kind, isByte, addr, data, alu, rd, wr, mov);
      total++; if (gotStalls != expStalls) begin bad++; $display("FAIL rnd_stalls op=%0d addr=%h got=%0d want=%0d", n, addr, gotStalls, expStalls); end
      if (kind == 1) begin
        total++; if (gotWb !== expLoad) begin bad++; $display("FAIL rnd_load op=%0d addr=%h got=%h want=%h", n, addr, gotWb, expLoad); end
      end else if (kind == 0) begin
        total++; if (gotWb !== alu) begin bad++; $display("FAIL rnd_alu op=%0d got=%h want=%h", n, gotWb, alu); end
      end
      total++; if (gotRd !== rd || gotWr !== (wr && kind < 2) || gotMov !== mov) begin bad++;
        $display("FAIL rnd_ctrl op=%0d got=%0d/%b/%b want=%0d/%b/%b", n, gotRd, gotWr, gotMov, rd, wr && kind < 2, mov); end
      total++; if ((nEvict - evBefore) != int'(expEvict) || (expEvict && (lastEvictAddr !== expEvictAddr || lastEvictData !== expEvictData))) begin bad++;
        $display("FAIL rnd_evict op=%0d n=%0d addr=%h want=%0d/%h", n, nEvict - evBefore, lastEvictAddr, expEvict, expEvictAddr); end
      total++; if ((nFill - fillBefore) != int'(expFill) || (expFill && lastFillAddr !== (addr & 32'hFFFF_FFF0))) begin bad++;
        $display("FAIL rnd_fill op=%0d n=%0d addr=%h want=%0d", n, nFill - fillBefore, lastFillAddr, expFill); end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b1; ex_rd = 5'd31; ex_is_write = 1'b1; ex_mov_rm = 1'b1; ex_alu_result = $urandom;
        #1;
        total++; if ({wb_data_out, rd_out, is_write_out, mov_rm_out, stall_mem} !== 40'h0) begin bad++;
          $display("FAIL rnd_invalid_slot got=%h/%0d/%b/%b/%b want=0", wb_data_out, rd_out, is_write_out, mov_rm_out, stall_mem); end
        ex_is_load = 1'b0;
      end
    end
    memDelay = 0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mValid[i] = 0; mDirty[i] = 0; mLine[i] = 0;
    end
    test_reset();
    test_cold_load();
    test_byte_store_load();
    test_dirty_conflict();
    test_alu();
    test_reset_in_fill();
    test_slow_memory();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
